// File: rtl/pucch_pkg.sv
// Shared definitions for the PUCCH Gold-sequence scrambler.
// Holds the default fast-forward offset, the x1 load value, the index
// width and the controller state encoding used by pucch_scrambler.
package pucch_pkg;

  // Gold-sequence fast-forward offset Nc.
  localparam int NC_DEFAULT = 1600;

  // Default number of LFSR advances per warm-up cycle.
  localparam int STEP_DEFAULT = 8;

  // x1 always starts from a single 1 in position 0.
  localparam logic [30:0] X1_INIT = 31'h1;

  // Width of the per-bit symbol index handed to the mapper.
  localparam int IDX_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/gold_lfsr_step.sv
// gold_lfsr_step: advances the Gold-sequence LFSR pair {x1, x2} by N steps.
// Purely combinational; bit k of each state vector holds x(n+k), so bit 0
// is the current output tap and the feedback bit enters at position 30.
// Ports: i_x1/i_x2 present state, o_x1/o_x2 state after N advances.
module gold_lfsr_step #(
  parameter int N = 1
) (
  input  logic [30:0] i_x1,
  input  logic [30:0] i_x2,
  output logic [30:0] o_x1,
  output logic [30:0] o_x2
);

  logic [30:0] x1_v;
  logic [30:0] x2_v;

  // Unrolled chain of single-step shifts:
  //   x1(n+31) = x1(n+3) ^ x1(n)
  //   x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
  always_comb begin
    x1_v = i_x1;
    x2_v = i_x2;
    for (int k = 0; k < N; k++) begin
      x1_v = {x1_v[3] ^ x1_v[0], x1_v[30:1]};
      x2_v = {x2_v[3] ^ x2_v[2] ^ x2_v[1] ^ x2_v[0], x2_v[30:1]};
    end
    o_x1 = x1_v;
    o_x2 = x2_v;
  end

endmodule

// File: rtl/pucch_scrambler.sv
// pucch_scrambler: Gold-sequence scrambler for PUCCH formats 3/4, feeding
// the pi/2-BPSK mapper one scrambled bit plus its symbol index per handshake.
// Per codeword: latch seed/length on i_start, fast-forward the generator by
// NC in NC/STEP warm-up cycles, then XOR each input bit with c(n).
// Ports: i_clk/i_rst_n; i_start, i_c_init, i_num_bits (codeword setup);
// i_valid/i_b/o_ready (upstream bits); o_valid/o_b/o_index/i_ready (mapper);
// o_busy (WARMUP or RUN), o_done (one-cycle end-of-codeword pulse).
// Latency 1 cycle from input transfer to o_valid, full throughput; outputs
// hold while o_valid & ~i_ready.
// Build option PUCCH_SCR_BYPASS_EN adds i_bypass (latched at i_start) which
// passes bits through unscrambled while keeping warm-up and handshake.
module pucch_scrambler
  import pucch_pkg::*;
#(
  parameter int NC   = NC_DEFAULT,
  parameter int STEP = STEP_DEFAULT  // must divide NC
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [30:0]      i_c_init,
  input  logic [IDX_W-1:0] i_num_bits,
  input  logic             i_valid,
  input  logic             i_b,
  output logic             o_ready,
  output logic             o_valid,
  output logic             o_b,
  output logic [IDX_W-1:0] o_index,
  input  logic             i_ready,
  output logic             o_busy,
`ifdef PUCCH_SCR_BYPASS_EN
  input  logic             i_bypass,
`endif
  output logic             o_done
);

  localparam int WARM_CYC = NC / STEP;
  localparam int WC_W     = $clog2(WARM_CYC + 1);
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARM_CYC - 1);

  state_e           state_q;
  logic [30:0]      x1_q, x2_q;
  logic [30:0]      x1_warm_d, x2_warm_d;
  logic [30:0]      x1_run_d, x2_run_d;
  logic [WC_W-1:0]  warm_cnt_q;
  logic [IDX_W-1:0] cnt_q;        // inputs accepted so far
  logic [IDX_W-1:0] num_bits_q;
  logic             vld_q;
  logic             b_q;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
`ifdef PUCCH_SCR_BYPASS_EN
  logic             bypass_q;
`endif

  logic c_bit;
  logic scr_bit;
  logic take_ok;
  logic in_xfer;
  logic out_xfer;
  logic last_out;

  // Warm-up path: STEP advances per cycle.
  gold_lfsr_step #(.N(STEP)) u_step_warm (
    .i_x1 (x1_q),
    .i_x2 (x2_q),
    .o_x1 (x1_warm_d),
    .o_x2 (x2_warm_d)
  );

  // Run path: one advance per accepted bit.
  gold_lfsr_step #(.N(1)) u_step_run (
    .i_x1 (x1_q),
    .i_x2 (x2_q),
    .o_x1 (x1_run_d),
    .o_x2 (x2_run_d)
  );

  assign c_bit = x1_q[0] ^ x2_q[0];

`ifdef PUCCH_SCR_BYPASS_EN
  assign scr_bit = bypass_q ? i_b : (i_b ^ c_bit);
`else
  assign scr_bit = i_b ^ c_bit;
`endif

  // Accept input only in RUN, only while bits remain, and only when the
  // single output register is empty or draining this cycle.
  assign take_ok  = (state_q == RUN) && (cnt_q < num_bits_q) && (!vld_q || i_ready);
  assign o_ready  = take_ok;
  assign in_xfer  = take_ok && i_valid;
  assign out_xfer = vld_q && i_ready;
  // num_bits_q >= 1 whenever RUN is active, so the subtraction cannot wrap.
  assign last_out = out_xfer && (idx_q == (num_bits_q - 16'd1));

  assign o_valid = vld_q;
  assign o_b     = b_q;
  assign o_index = idx_q;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      x1_q       <= '0;
      x2_q       <= '0;
      warm_cnt_q <= '0;
      cnt_q      <= '0;
      num_bits_q <= '0;
      vld_q      <= 1'b0;
      b_q        <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
`ifdef PUCCH_SCR_BYPASS_EN
      bypass_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            x1_q       <= X1_INIT;
            x2_q       <= i_c_init;
            num_bits_q <= i_num_bits;
            cnt_q      <= '0;
            warm_cnt_q <= '0;
`ifdef PUCCH_SCR_BYPASS_EN
            bypass_q   <= i_bypass;
`endif
            state_q    <= WARMUP;
          end
        end

        WARMUP: begin
          x1_q       <= x1_warm_d;
          x2_q       <= x2_warm_d;
          warm_cnt_q <= warm_cnt_q + WC_W'(1);
          if (warm_cnt_q == WARM_LAST) begin
            // An empty codeword finishes right after the warm-up.
            if (num_bits_q == '0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          if (in_xfer) begin
            b_q   <= scr_bit;
            idx_q <= cnt_q;
            cnt_q <= cnt_q + 16'd1;
            x1_q  <= x1_run_d;
            x2_q  <= x2_run_d;
            vld_q <= 1'b1;
          end else if (out_xfer) begin
            vld_q <= 1'b0;
          end
          // The last bit cannot coincide with a new input: cnt_q has
          // already reached num_bits_q by then.
          if (last_out) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pucch_scrambler.sv
module tb_pucch_scrambler;

  localparam int NC   = 1600;
  localparam int MAXB = 256;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [30:0] c_init;
  logic [15:0] num_bits;
  logic        in_valid;
  logic        in_b;
  logic        out_ready_up;
  logic        out_valid;
  logic        out_b;
  logic [15:0] out_index;
  logic        mapper_ready;
  logic        busy;
  logic        done;
`ifdef PUCCH_SCR_BYPASS_EN
  logic        bypass;
`endif

  pucch_scrambler dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_c_init   (c_init),
    .i_num_bits (num_bits),
    .i_valid    (in_valid),
    .i_b        (in_b),
    .o_ready    (out_ready_up),
    .o_valid    (out_valid),
    .o_b        (out_b),
    .o_index    (out_index),
    .i_ready    (mapper_ready),
    .o_busy     (busy),
`ifdef PUCCH_SCR_BYPASS_EN
    .i_bypass   (bypass),
`endif
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Golden Gold-sequence model, computed straight from the recurrences.
  bit x1m [0:NC+MAXB+31];
  bit x2m [0:NC+MAXB+31];
  bit c_ref [0:MAXB-1];
  bit b_in  [0:MAXB-1];

  task automatic gen_c(input logic [30:0] seed, input int len);
    for (int k = 0; k < 31; k++) begin
      x1m[k] = (k == 0);
      x2m[k] = seed[k];
    end
    for (int n = 0; n + 31 <= NC + len; n++) begin
      x1m[n+31] = x1m[n+3] ^ x1m[n];
      x2m[n+31] = x2m[n+3] ^ x2m[n+2] ^ x2m[n+1] ^ x2m[n];
    end
    for (int n = 0; n < len; n++) c_ref[n] = x1m[NC+n] ^ x2m[NC+n];
  endtask

  typedef struct {
    logic [30:0] seed;
    int          len;
    int          vld_pct;
    int          rdy_pct;
    int          bmode;      // 0 zeros, 1 random, 2 pattern 16'hA5C3
    bit          mid_start;  // pulse i_start (other seed) during RUN
    int          exp_lat;    // cycles from i_start to RUN (or to o_done if len 0)
  } vec_t;

  task automatic run_cw(input vec_t v, input int abort_at, input bit byp);
    int k, in_ptr, rcv, cyc, budget, dones_seen;
    bit saw_valid, hold_pend, mid_done;
    logic hold_b;
    logic [15:0] hold_idx;
    logic [15:0] pat;
    logic exp_b;
    pat = 16'hA5C3;
    gen_c(v.seed, v.len);
    for (int n = 0; n < v.len; n++) begin
      case (v.bmode)
        0:       b_in[n] = 1'b0;
        1:       b_in[n] = 1'($urandom_range(1));
        default: b_in[n] = pat[n % 16];
      endcase
    end
    @(negedge clk);
    start = 1'b1; c_init = v.seed; num_bits = 16'(v.len);
    in_valid = 1'b0; in_b = 1'b0; mapper_ready = 1'b0;
`ifdef PUCCH_SCR_BYPASS_EN
    bypass = byp;
`endif
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    k = 1;
    saw_valid = 0;
    while (k < 400 && !((v.len == 0) ? done : out_ready_up)) begin
      if (out_valid) saw_valid = 1;
      @(negedge clk);
      k++;
    end
    check((v.len == 0) ? "done_latency" : "run_latency", k, v.exp_lat);
    if (v.len == 0) begin
      check("len0_no_valid", saw_valid, 0);
      @(negedge clk);
      check("len0_done_pulse_end", done, 0);
      check("len0_idle", busy, 0);
      return;
    end
    in_ptr = 0; rcv = 0; cyc = 0; dones_seen = 0;
    hold_pend = 0; mid_done = 0;
    budget = 200 + v.len * 40;
    while (rcv < v.len && cyc < budget) begin
      if (abort_at >= 0 && rcv == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_b", out_b, 0);
        check("rst_index", out_index, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", out_ready_up, 0);
        check("rst_done", done, 0);
        in_valid = 1'b0; mapper_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      in_valid     = (in_ptr < v.len) && ($urandom_range(99) < v.vld_pct);
      in_b         = (in_ptr < v.len) ? b_in[in_ptr] : 1'b0;
      mapper_ready = ($urandom_range(99) < v.rdy_pct);
      if (v.mid_start && in_ptr == 5 && !mid_done) begin
        start = 1'b1; c_init = ~v.seed; num_bits = 16'd3; mid_done = 1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (hold_pend) begin
        check("stall_valid", out_valid, 1);
        check("stall_b", out_b, hold_b);
        check("stall_index", out_index, hold_idx);
        hold_pend = 0;
      end
      if (done) dones_seen++;
      if (out_valid && mapper_ready) begin
        exp_b = byp ? b_in[rcv] : (b_in[rcv] ^ c_ref[rcv]);
        check("bit", out_b, exp_b);
        check("index", out_index, rcv);
        rcv++;
      end else if (out_valid) begin
        hold_pend = 1; hold_b = out_b; hold_idx = out_index;
      end
      if (in_valid && out_ready_up) in_ptr++;
      @(negedge clk);
      cyc++;
    end
    check("all_bits_out", rcv, v.len);
    check("inputs_taken", in_ptr, v.len);
    start = 1'b0; in_valid = 1'b0;
    check("no_early_done", dones_seen, 0);
    check("done_pulse", done, 1);
    check("busy_low_at_done", busy, 0);
    @(negedge clk);
    check("done_single", done, 0);
    check("valid_low_after", out_valid, 0);
  endtask

  vec_t vecs [5];

  initial begin
    vec_t vr;
    vecs[0] = '{31'h0,        32,  100, 100, 0, 0, 201};
    vecs[1] = '{31'h12345678, 100, 100, 100, 1, 0, 201};
    vecs[2] = '{31'h05A5A5A5, 64,  30,  50,  1, 0, 201};
    vecs[3] = '{31'h7,        0,   100, 100, 0, 0, 201};
    vecs[4] = '{31'h01ABCDEF, 40,  100, 100, 1, 1, 201};

    rst_n = 1'b0; start = 1'b0; c_init = '0; num_bits = '0;
    in_valid = 1'b0; in_b = 1'b0; mapper_ready = 1'b0;
`ifdef PUCCH_SCR_BYPASS_EN
    bypass = 1'b0;
`endif
    #3;
    check("reset_ready", out_ready_up, 0);
    check("reset_valid", out_valid, 0);
    check("reset_b", out_b, 0);
    check("reset_index", out_index, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_cw(vecs[i], -1, 1'b0);

    // Reset in the middle of a codeword, then a clean restart from index 0.
    vr = '{31'h00C0FFEE, 32, 100, 100, 1, 0, 201};
    run_cw(vr, 10, 1'b0);
    vr = '{31'h3, 20, 100, 70, 1, 0, 201};
    run_cw(vr, -1, 1'b0);

`ifdef PUCCH_SCR_BYPASS_EN
    vr = '{31'h0BADCAFE, 16, 100, 100, 2, 0, 201};
    run_cw(vr, -1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pucch_scrambler.md
# pucch_scrambler

Gold-sequence scrambler for PUCCH formats 3/4 (TS 38.211 §5.2.1, §6.3.2.6.1). It sits directly upstream of the π/2-BPSK mapper. Per codeword it:
- takes the encoded bit stream and the scrambling seed c_init,
- fast-forwards the Gold generator by Nc = 1600,
- XORs each input bit with c(n),
- hands the mapper one scrambled bit plus its 16-bit symbol index per handshake.

## Interface

Parameters:
- NC, 1600, Gold-sequence fast-forward offset.
- STEP, 8, LFSR advances per warm-up cycle; must divide NC.

Ports (clock and reset first):
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset; single clock domain.
- i_start  in  1  one-cycle pulse; latches i_c_init and i_num_bits; honoured only in IDLE.
- i_c_init  in  31  scrambling seed.
- i_num_bits  in  16  codeword length in bits, 0..65535.
- i_valid  in  1  upstream bit valid.
- i_b  in  1  upstream bit.
- o_ready  out  1  upstream may transfer (i_valid & o_ready).
- o_valid  out  1  scrambled bit valid toward the mapper.
- o_b  out  1  scrambled bit b~(n) = b(n) ^ c(n).
- o_index  out  16  n, 0-based, feeds the mapper index input.
- i_ready  in  1  mapper accepts (o_valid & i_ready).
- o_busy  out  1  high in WARMUP and RUN.
- o_done  out  1  one-cycle pulse at end of codeword.

## Operation

Generator:
- x1 loads {30'b0, 1'b1}; x2 loads i_c_init.
- x1(n+31) = x1(n+3) ^ x1(n).
- x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n).
- c(n) = x1(0) ^ x2(0) after the generator has advanced NC+n steps.

FSM states:
- IDLE: o_ready=0. On i_start: latch seed and length, clear bit counter, go to WARMUP.
- WARMUP: advance both LFSRs STEP positions per cycle for NC/STEP cycles (200 at default). Then go to RUN, or to IDLE with an o_done pulse if length = 0.
- RUN: o_ready = ~o_valid | i_ready (single output register, full throughput).
  - On an input transfer: o_b = i_b ^ c, o_index = counter, counter++, LFSRs advance 1 step.
  - When the transfer of bit num_bits-1 to the mapper completes: go to IDLE and pulse o_done.

Rules:
- o_b, o_index and o_valid are held stable while o_valid & ~i_ready.
- i_start outside IDLE is ignored.
- i_valid outside RUN is ignored.
- o_index is 16 bits; the counter never wraps because the maximum length is 65535.
- No input transfer is accepted once num_bits inputs have been taken.

## Timing

- Reset values: o_ready=0, o_valid=0, o_b=0, o_index=0, o_busy=0, o_done=0, FSM=IDLE, LFSRs=0.
- i_start sampled in cycle t: o_busy rises at t+1; RUN entered at t+1+NC/STEP.
- First input transfer in cycle k: o_valid at k+1 (latency 1).
- Throughput: 1 bit/cycle with i_valid and i_ready held high.
- Last bit transferred to the mapper at cycle m: o_done at m+1, o_busy low at m+1.
- Reset asserted mid-operation: all state returns to reset values immediately; any partial codeword is discarded.

## Configuration

- PUCCH_SCR_BYPASS_EN defined:
  - adds input port i_bypass (1 bit), latched at i_start;
  - when the latched value is 1, WARMUP still occurs but o_b = i_b (no XOR);
  - o_index and the handshake are unchanged.
- Undefined: no i_bypass port; scrambling is always applied.

## Structure

- Shared package pucch_pkg:
  - NC_DEFAULT = 1600;
  - X1_INIT = 31'h1;
  - FSM state enum {IDLE, WARMUP, RUN};
  - index width constant IDX_W = 16.
- One sub-module, gold_lfsr_step: combinational, advances the {x1,x2} pair by a parameterised number of steps. Instantiated once with STEP (warm-up) and once with 1 (run). The FSM, counter and output register stay in pucch_scrambler.

## Test plan

- Seed 0, length 32, i_b all 0:
  - o_b equals the golden c(0..31) for c_init=0;
  - o_index runs 0..31;
  - o_done fires exactly once, one cycle after the last transfer.
- Seed 31'h12345678 masked to 31 bits, length 100, random i_b:
  - o_b equals the model b ^ c;
  - RUN is entered exactly 201 cycles after i_start.
- i_ready toggling 50%, i_valid toggling 30%, length 64:
  - no bit lost or duplicated;
  - o_b and o_index held stable during stalls.
- Length 0: o_done fires after warm-up, o_valid never asserts, FSM returns to IDLE.
- i_start pulsed during RUN: ignored, output sequence unchanged. Reset asserted at bit 10: all outputs return to 0; a new i_start restarts at o_index 0.
- PUCCH_SCR_BYPASS_EN defined with i_bypass=1, length 16, i_b = 16'hA5C3: o_b reproduces 16'hA5C3 bit-for-bit, o_index runs 0..15.
